// File: rtl/iir_coeff_loader.sv
// Loads a biquad IIR coefficient set from a checksummed 19-byte stream frame
// into a shadow copy, then commits the whole set at once on a sample strobe.
module iir_coeff_loader #(
    parameter logic [39:0] DEF_CX  = 40'h000040FC99,
    parameter logic [7:0]  DEF_CX0 = 8'd3,
    parameter logic [7:0]  DEF_CX1 = 8'd3,
    parameter logic [7:0]  DEF_CX2 = 8'd1,
    parameter logic [23:0] DEF_CY0 = 24'h000000,
    parameter logic [23:0] DEF_CY1 = 24'h000000,
    parameter logic [23:0] DEF_CY2 = 24'h000000,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_ce,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic        loaded,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECKSUM,
        PENDING
    } state_t;

    typedef struct packed {
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } coeff_t;

    localparam logic [7:0] HEADER           = 8'hA5;
    localparam logic [4:0] LAST_PAYLOAD_IDX = 5'd17;
    localparam coeff_t     DEF_SET          = '{
        cx:  DEF_CX,
        cx0: DEF_CX0,
        cx1: DEF_CX1,
        cx2: DEF_CX2,
        cy0: DEF_CY0,
        cy1: DEF_CY1,
        cy2: DEF_CY2
    };

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  xor_q, xor_d;
    logic [15:0] tmo_q, tmo_d;
    coeff_t      shadow_q, shadow_d;
    coeff_t      coef_q, coef_d;
    logic        loaded_q, loaded_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        tmo_hit;
    logic        reject;

    // Multi-byte fields arrive least-significant byte first.
    function automatic coeff_t write_field(input coeff_t s, input logic [4:0] idx,
                                           input logic [7:0] b);
        coeff_t r;
        r = s;
        case (idx)
            5'd1:    r.cx[7:0]   = b;
            5'd2:    r.cx[15:8]  = b;
            5'd3:    r.cx[23:16] = b;
            5'd4:    r.cx[31:24] = b;
            5'd5:    r.cx[39:32] = b;
            5'd6:    r.cx0       = b;
            5'd7:    r.cx1       = b;
            5'd8:    r.cx2       = b;
            5'd9:    r.cy0[7:0]   = b;
            5'd10:   r.cy0[15:8]  = b;
            5'd11:   r.cy0[23:16] = b;
            5'd12:   r.cy1[7:0]   = b;
            5'd13:   r.cy1[15:8]  = b;
            5'd14:   r.cy1[23:16] = b;
            5'd15:   r.cy2[7:0]   = b;
            5'd16:   r.cy2[15:8]  = b;
            5'd17:   r.cy2[23:16] = b;
            default: r = s;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q != PENDING);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid & in_ready;
    assign tmo_hit  = (tmo_q == TIMEOUT - 16'd1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        coef_d   = coef_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        reject   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && in_data == HEADER) begin
                    state_d = PAYLOAD;
                    idx_d   = 5'd1;
                    xor_d   = '0;
                    tmo_d   = '0;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    shadow_d = write_field(shadow_q, idx_q, in_data);
                    xor_d    = xor_q ^ in_data;
                    idx_d    = idx_q + 5'd1;
                    tmo_d    = '0;
                    if (idx_q == LAST_PAYLOAD_IDX) begin
                        state_d = CHECKSUM;
                    end
                end else if (tmo_hit) begin
                    reject = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            CHECKSUM: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d = PENDING;
                        tmo_d   = '0;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (tmo_hit) begin
                    reject = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            PENDING: begin
                // Entry edge is the checksum edge, so a strobe coincident with
                // the checksum byte can never commit.
                if (sample_ce) begin
                    coef_d   = shadow_q;
                    done_d   = 1'b1;
                    loaded_d = 1'b1;
                    state_d  = IDLE;
                    idx_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reject) begin
            err_d    = 1'b1;
            state_d  = IDLE;
            idx_d    = '0;
            xor_d    = '0;
            tmo_d    = '0;
            shadow_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            xor_q    <= '0;
            tmo_q    <= '0;
            shadow_q <= '0;
            coef_q   <= DEF_SET;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            coef_q   <= coef_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cx     = coef_q.cx;
    assign cx0    = coef_q.cx0;
    assign cx1    = coef_q.cx1;
    assign cx2    = coef_q.cx2;
    assign cy0    = coef_q.cy0;
    assign cy1    = coef_q.cy1;
    assign cy2    = coef_q.cy2;
    assign loaded = loaded_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Scoreboard bench for iir_coeff_loader: the driver queues expected commit and
// reject events, a negedge monitor pops them and tracks the committed set.
module tb_iir_coeff_loader;

    typedef struct packed {
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } coeff_t;

    typedef struct {
        bit     is_err;
        int     exp_cyc;
        coeff_t c;
    } ev_t;

    typedef logic [7:0] frame_t [19];

    localparam coeff_t DEF_SET = '{cx: 40'h000040FC99, cx0: 8'h03, cx1: 8'h03, cx2: 8'h01,
                                   cy0: 24'h000000, cy1: 24'h000000, cy2: 24'h000000};
    localparam coeff_t SET_A   = '{cx: 40'h0102030405, cx0: 8'h03, cx1: 8'h03, cx2: 8'h01,
                                   cy0: 24'hA5B6C7, cy1: 24'h5DF0E1, cy2: 24'h8484F4};
    localparam coeff_t SET_B   = '{cx: 40'hFFEEDDCCBB, cx0: 8'hA5, cx1: 8'h7E, cx2: 8'h10,
                                   cy0: 24'h332211, cy1: 24'h665544, cy2: 24'h998877};

    // Checksums worked by hand: frame A -> 6C, frame B -> 61.
    frame_t frame_a = '{8'hA5, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h03, 8'h03, 8'h01,
                        8'hC7, 8'hB6, 8'hA5, 8'hE1, 8'hF0, 8'h5D, 8'hF4, 8'h84, 8'h84, 8'h6C};
    frame_t frame_b = '{8'hA5, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hA5, 8'h7E, 8'h10,
                        8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h61};

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;
    logic        loaded, done, err, busy;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    ev_t    q[$];
    ev_t    ev;
    coeff_t cur = DEF_SET;
    coeff_t got;
    bit     exp_loaded = 1'b0;
    int     c0, c1, hdr_cyc, commit_cyc;
    frame_t bad;

    iir_coeff_loader #(.TIMEOUT(16'd16)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_ce (sample_ce),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cx        (cx),
        .cx0       (cx0),
        .cx1       (cx1),
        .cx2       (cx2),
        .cy0       (cy0),
        .cy1       (cy1),
        .cy2       (cy2),
        .loaded    (loaded),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign got = {cx, cx0, cx1, cx2, cy0, cy1, cy2};

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT done/err must match the next queued event.
    always @(negedge clk) begin
        if (reset) begin
            cur        = DEF_SET;
            exp_loaded = 1'b0;
            chk("reset_in_ready", in_ready, 1);
            chk("reset_busy", busy, 0);
        end
        chk("done_err_exclusive", done & err, 0);
        if (done || err) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {done, err}, 0);
            end else begin
                ev = q.pop_front();
                chk("event_kind", err, ev.is_err);
                chk("event_cycle", cyc, ev.exp_cyc);
                chk("event_busy", busy, 0);
                if (!ev.is_err) begin
                    cur        = ev.c;
                    exp_loaded = 1'b1;
                end
            end
        end
        chk("coeffs", got, cur);
        chk("loaded", loaded, exp_loaded);
    end

    task automatic push_ev(input bit is_err, input int exp_cyc, input coeff_t c);
        ev_t e;
        e.is_err  = is_err;
        e.exp_cyc = exp_cyc;
        e.c       = c;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit sce, output int acc_cyc);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1;
        in_data  = b;
        if (sce) sample_ce = 1'b1;
        while (!ok && n < 200) begin
            ok = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (sce) sample_ce = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: in_ready stayed 0 for %0d cycles, expected 1", n);
        end
    endtask

    task automatic send_bytes(input frame_t f, input int n, output int first_cyc,
                              output int last_cyc);
        int c;
        first_cyc = 0;
        last_cyc  = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(f[i], 1'b0, c);
            if (i == 0) first_cyc = c;
            last_cyc = c;
        end
    endtask

    task automatic commit_after(input int wait_n, input coeff_t c, output int commit_at);
        repeat (wait_n) @(negedge clk);
        commit_at = cyc + 1;
        push_ev(1'b0, commit_at, c);
        sample_ce = 1'b1;
        @(negedge clk);
        sample_ce = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        sample_ce = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Corrupted checksum: reject pulse, defaults kept.
        bad     = frame_a;
        bad[18] = bad[18] ^ 8'h01;
        send_bytes(bad, 18, c0, c1);
        push_ev(1'b1, cyc + 1, DEF_SET);
        send_byte(bad[18], 1'b0, c1);
        repeat (3) @(negedge clk);

        // Frame A; strobe coincident with checksum must not commit.
        send_bytes(frame_a, 18, c0, c1);
        send_byte(frame_a[18], 1'b1, c1);
        chk("pending_in_ready", in_ready, 0);
        chk("pending_busy", busy, 1);
        commit_after(10, SET_A, commit_cyc);
        repeat (3) @(negedge clk);

        // Leading junk ignored, then frame B (0xA5 inside payload is data).
        send_byte(8'h00, 1'b0, c1);
        send_byte(8'hFF, 1'b0, c1);
        send_byte(8'h12, 1'b0, c1);
        chk("junk_busy", busy, 0);
        send_bytes(frame_b, 19, c0, c1);
        commit_after(3, SET_B, commit_cyc);
        repeat (3) @(negedge clk);

        // Frame A, then frame B offered while PENDING: held off until the commit.
        send_bytes(frame_a, 19, c0, c1);
        fork
            send_bytes(frame_b, 19, hdr_cyc, c1);
            commit_after(5, SET_A, commit_cyc);
        join
        chk("resume_after_done", hdr_cyc, commit_cyc + 1);
        commit_after(2, SET_B, commit_cyc);
        repeat (3) @(negedge clk);

        // Stall after byte 9 until the timeout fires, then a clean frame A.
        send_bytes(frame_b, 10, c0, c1);
        push_ev(1'b1, c1 + 16, DEF_SET);
        repeat (20) @(negedge clk);
        chk("timeout_busy", busy, 0);
        send_bytes(frame_a, 19, c0, c1);
        commit_after(2, SET_A, commit_cyc);
        repeat (3) @(negedge clk);

        // Reset after byte 12: frame dropped, strobe afterwards commits nothing.
        send_bytes(frame_b, 13, c0, c1);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        sample_ce = 1'b1;
        @(negedge clk);
        sample_ce = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        send_bytes(frame_b, 19, c0, c1);
        commit_after(4, SET_B, commit_cyc);
        repeat (5) @(negedge clk);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
